count_monitor: RTL and testbench

- Receive-side checker for the up/down counter's output stream.
- Samples `count` and `select` every clock and predicts the next value.
- Locks once the stream behaves like a legal counter; flags and counts every deviation after lock.
- Also reports wrap-around events.
- Sits beside the counter in benches and in-system as a self-check/observability block.

---
 rtl/count_monitor.sv | 107 ++++++++++
 tb/tb_count_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Receive-side checker for an up/down counter stream: predicts each sample from
// the previous one, locks after LOCK_N clean predictions, then flags mismatches and wraps.
module count_monitor #(
    parameter int bits   = 4,
    parameter int ERR_W  = 8,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             select,
    input  logic [bits-1:0]  count,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count,
    output logic             dir
);

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    localparam logic [3:0]       LOCK_V   = 4'(LOCK_N);
    localparam logic [bits-1:0]  ONE_C    = bits'(1);
    localparam logic [ERR_W-1:0] ONE_E    = ERR_W'(1);

    state_t          state, state_nxt;
    logic [3:0]      match_cnt, match_nxt;
    logic [bits-1:0] prev_count, expected;
    logic            prev_sel;
    logic            hit, up_wrap, down_wrap;
    logic            mismatch_nxt, wrap_nxt;

    // The counter applies select at the edge it updates, so predict with the
    // select that was sampled alongside the previous count.
    assign expected  = prev_sel ? (prev_count - ONE_C) : (prev_count + ONE_C);
    assign hit       = (count == expected);
    assign up_wrap   = !prev_sel && (prev_count == '1) && (count == '0);
    assign down_wrap =  prev_sel && (prev_count == '0) && (count == '1);

    always_comb begin
        state_nxt    = state;
        match_nxt    = match_cnt;
        mismatch_nxt = 1'b0;
        wrap_nxt     = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = SYNC;
                match_nxt = '0;
            end
            SYNC: begin
                if (hit) begin
                    if (match_cnt + 4'd1 >= LOCK_V) begin
                        state_nxt = LOCKED;
                        match_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + 4'd1;
                    end
                end else begin
                    match_nxt = '0;
                end
            end
            LOCKED: begin
                if (hit) begin
                    wrap_nxt = up_wrap || down_wrap;
                end else begin
                    mismatch_nxt = 1'b1;
                    state_nxt    = SYNC;
                    match_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                match_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            match_cnt  <= '0;
            prev_count <= '0;
            prev_sel   <= 1'b0;
            dir        <= 1'b0;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            wrap       <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_nxt;
            match_cnt  <= match_nxt;
            prev_count <= count;
            prev_sel   <= select;
            dir        <= select;
            locked     <= (state_nxt == LOCKED);
            mismatch   <= mismatch_nxt;
            wrap       <= wrap_nxt;
            // Saturating counters hold at all-ones; the pulses still fire.
            if (mismatch_nxt && (err_count != '1))
                err_count <= err_count + ONE_E;
            if (wrap_nxt && (wrap_count != '1))
                wrap_count <= wrap_count + ONE_E;
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: default instance plus an ERR_W=2 instance
// sharing the same stimulus for the saturation scenario.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       select = 1'b0;
    logic [3:0] count = 4'd0;

    logic       locked, mismatch, wrap, dir;
    logic [7:0] err_count, wrap_count;
    logic       locked2, mismatch2, wrap2, dir2;
    logic [1:0] err_count2, wrap_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_monitor #(.bits(4), .ERR_W(8), .LOCK_N(2)) dut (
        .clk(clk), .rst(rst), .select(select), .count(count),
        .locked(locked), .mismatch(mismatch), .wrap(wrap),
        .err_count(err_count), .wrap_count(wrap_count), .dir(dir)
    );

    count_monitor #(.bits(4), .ERR_W(2), .LOCK_N(2)) dut2 (
        .clk(clk), .rst(rst), .select(select), .count(count),
        .locked(locked2), .mismatch(mismatch2), .wrap(wrap2),
        .err_count(err_count2), .wrap_count(wrap_count2), .dir(dir2)
    );

    // One sample: inputs change on the falling edge, outputs read 1 time unit after the rising edge.
    task automatic drive(input logic r, input int c, input logic s);
        @(negedge clk);
        rst    = r;
        count  = 4'(c & 15);
        select = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 0, 1'b0);
        checks++;
        if ({locked, mismatch, wrap, dir, err_count, wrap_count} !== 20'd0) begin
            $display("FAIL reset_state: got l=%b m=%b w=%b d=%b err=%0d wc=%0d, want all 0",
                     locked, mismatch, wrap, dir, err_count, wrap_count);
            errors++;
        end
    endtask

    task automatic test_lock;
        logic exp_l [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i, 1'b0);
            checks++;
            if (locked !== exp_l[i]) begin
                $display("FAIL lock_seq sample %0d: locked=%b want %b", i, locked, exp_l[i]);
                errors++;
            end
        end
        checks++;
        if (err_count !== 8'd0 || dir !== 1'b0) begin
            $display("FAIL lock_state: err=%0d dir=%b want 0 0", err_count, dir);
            errors++;
        end
    endtask

    task automatic test_up_wrap;
        int seen_mm = 0;
        for (int v = 4; v <= 17; v++) begin
            drive(1'b0, v, 1'b0);
            if (mismatch) seen_mm++;
            checks++;
            if (wrap !== ((v & 15) == 0)) begin
                $display("FAIL up_wrap_pulse sample %0d: wrap=%b want %b", v & 15, wrap, (v & 15) == 0);
                errors++;
            end
        end
        checks++;
        if (wrap_count !== 8'd1 || seen_mm != 0 || locked !== 1'b1) begin
            $display("FAIL up_wrap_count: wc=%0d mm_seen=%0d locked=%b want 1 0 1", wrap_count, seen_mm, locked);
            errors++;
        end
    endtask

    task automatic test_dir_change;
        int seen_mm = 0;
        for (int v = 2; v <= 5; v++) drive(1'b0, v, 1'b0);
        checks++;
        if (dir !== 1'b0) begin
            $display("FAIL dir_before_toggle: dir=%b want 0", dir);
            errors++;
        end
        drive(1'b0, 6, 1'b1);
        checks++;
        if (dir !== 1'b1 || locked !== 1'b1) begin
            $display("FAIL dir_after_toggle: dir=%b locked=%b want 1 1", dir, locked);
            errors++;
        end
        for (int v = 5; v >= 0; v--) begin
            drive(1'b0, v, 1'b1);
            if (mismatch || wrap) seen_mm++;
        end
        drive(1'b0, 15, 1'b1);
        checks++;
        if (wrap !== 1'b1 || wrap_count !== 8'd2 || err_count !== 8'd0 || seen_mm != 0 || locked !== 1'b1) begin
            $display("FAIL down_wrap: wrap=%b wc=%0d err=%0d spurious=%0d locked=%b want 1 2 0 0 1",
                     wrap, wrap_count, err_count, seen_mm, locked);
            errors++;
        end
    endtask

    task automatic test_mismatch;
        drive(1'b1, 0, 1'b0);
        for (int v = 0; v <= 3; v++) drive(1'b0, v, 1'b0);
        drive(1'b0, 7, 1'b0);
        checks++;
        if (mismatch !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
            $display("FAIL jump_flag: mm=%b err=%0d locked=%b want 1 1 0", mismatch, err_count, locked);
            errors++;
        end
        drive(1'b0, 8, 1'b0);
        checks++;
        if (mismatch !== 1'b0 || locked !== 1'b0 || err_count !== 8'd1) begin
            $display("FAIL jump_after: mm=%b locked=%b err=%0d want 0 0 1", mismatch, locked, err_count);
            errors++;
        end
        drive(1'b0, 9, 1'b0);
        checks++;
        if (locked !== 1'b1 || mismatch !== 1'b0) begin
            $display("FAIL jump_relock: locked=%b mm=%b want 1 0", locked, mismatch);
            errors++;
        end
    endtask

    task automatic test_saturation;
        int v = 2;
        int pulses = 0;
        logic [1:0] exp_e2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive(1'b1, 0, 1'b0);
        for (int i = 0; i <= 2; i++) drive(1'b0, i, 1'b0);
        for (int i = 0; i < 5; i++) begin
            // First injection is a held value, the rest are forward jumps.
            v = (i == 0) ? v : v + 5;
            drive(1'b0, v, 1'b0);
            if (mismatch2) pulses++;
            checks++;
            if (err_count2 !== exp_e2[i] || err_count !== 8'(i + 1) || mismatch !== 1'b1) begin
                $display("FAIL sat_inject %0d: err2=%0d err=%0d mm=%b want %0d %0d 1",
                         i, err_count2, err_count, mismatch, exp_e2[i], i + 1);
                errors++;
            end
            drive(1'b0, v + 1, 1'b0);
            drive(1'b0, v + 2, 1'b0);
            v = v + 2;
            checks++;
            if (locked2 !== 1'b1 || mismatch2 !== 1'b0) begin
                $display("FAIL sat_relock %0d: locked2=%b mm2=%b want 1 0", i, locked2, mismatch2);
                errors++;
            end
        end
        checks++;
        if (pulses != 5) begin
            $display("FAIL sat_pulses: got %0d want 5", pulses);
            errors++;
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 0, 1'b0);
        for (int v = 0; v <= 17; v++) drive(1'b0, v, 1'b0);
        drive(1'b0, 9, 1'b0);
        drive(1'b0, 10, 1'b0);
        drive(1'b0, 11, 1'b0);
        drive(1'b0, 0, 1'b0);
        drive(1'b0, 1, 1'b0);
        drive(1'b0, 2, 1'b0);
        checks++;
        if (locked !== 1'b1 || err_count !== 8'd2 || wrap_count !== 8'd1) begin
            $display("FAIL mid_precond: locked=%b err=%0d wc=%0d want 1 2 1", locked, err_count, wrap_count);
            errors++;
        end
        drive(1'b1, 3, 1'b0);
        checks++;
        if ({locked, mismatch, wrap, dir, err_count, wrap_count} !== 20'd0) begin
            $display("FAIL mid_reset: got l=%b m=%b w=%b d=%b err=%0d wc=%0d, want all 0",
                     locked, mismatch, wrap, dir, err_count, wrap_count);
            errors++;
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5 + i, 1'b0);
            checks++;
            if (locked !== (i == 2)) begin
                $display("FAIL mid_relock sample %0d: locked=%b want %b", i, locked, i == 2);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_up_wrap;
        test_dir_change;
        test_mismatch;
        test_saturation;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
